// File: rtl/shreg_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: state encodings,
// default sizes and the bit-counter width helper.
package shreg_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_SHIFT   = ST_SHIFT,
        S_CAPTURE = ST_CAPTURE
    } state_t;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shreg_tick_div.sv
// Reloadable down-counter that sets the shift rate; tick is high while the
// count is zero, and the count parks at zero until the next reload.
module shreg_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        count_d = count_q;
        if (reload) begin
            count_d = div;
        end else if (count_q != '0) begin
            count_d = count_q - DIV_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Sequencer for the universal shift register: load a tx byte, shift it WIDTH
// times at a programmable rate, then capture the register as the rx byte.
module shreg_seq_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    output logic [WIDTH-1:0] reg_pdata,
    output logic             reg_load,
    output logic             reg_shr,
    output logic             reg_shl,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pdata_q, pdata_d, rx_q, rx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             msb_q, msb_d;
    logic             load_q, load_d, shr_q, shr_d, shl_q, shl_d;
    logic             rxv_q, rxv_d, busy_q, busy_d;

    logic             accept, counting, tick, fire;
    logic [DIV_W-1:0] reload_val;

    assign accept   = start_valid && (state_q == S_IDLE);
    assign counting = (state_q == S_LOAD) || (state_q == S_SHIFT);
    // The tick is decided one cycle ahead so the strobe itself can be registered.
    assign fire       = counting && tick && (bit_q < LAST_BIT) && !abort;
    assign reload_val = accept ? div : div_q;

    shreg_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .reload (accept || fire),
        .div    (reload_val),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        pdata_d = pdata_q;
        rx_d    = rx_q;
        div_d   = div_q;
        msb_d   = msb_q;
        bit_d   = bit_q;
        load_d  = 1'b0;
        shr_d   = 1'b0;
        shl_d   = 1'b0;
        rxv_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pdata_d = tx_data;
                    msb_d   = msb_first;
                    div_d   = div;
                    bit_d   = '0;
                    load_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ((shr_q || shl_q) && (bit_q == LAST_BIT)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rx_d    = reg_q;
                rxv_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            bit_d = bit_q + CNT_W'(1);
            shl_d = msb_q;
            shr_d = !msb_q;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    // NOTE: rst is synchronous and clears every register, including the data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pdata_q <= '0;
            rx_q    <= '0;
            div_q   <= '0;
            msb_q   <= 1'b0;
            bit_q   <= '0;
            load_q  <= 1'b0;
            shr_q   <= 1'b0;
            shl_q   <= 1'b0;
            rxv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pdata_q <= pdata_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            msb_q   <= msb_d;
            bit_q   <= bit_d;
            load_q  <= load_d;
            shr_q   <= shr_d;
            shl_q   <= shl_d;
            rxv_q   <= rxv_d;
            busy_q  <= busy_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign reg_pdata   = pdata_q;
    assign reg_load    = load_q;
    assign reg_shr     = shr_q;
    assign reg_shl     = shl_q;
    assign rx_data     = rx_q;
    assign rx_valid    = rxv_q;
    assign busy        = busy_q;

endmodule

// File: doc/shreg_seq_ctrl.md
Name: shreg_seq_ctrl

Overview:
Sequencer for the 8-bit universal shift register (parallel load, shift right/left, serial in/out). It accepts a transfer request through a valid/ready handshake and drives the register's load and shift strobes. It loads a tx byte, performs exactly WIDTH shifts at a programmable rate, then captures the register's parallel output as the rx byte. This gives a full-duplex, SPI-like byte exchange through the register's serial pins. It sits between the host logic and the shift register instance.

Parameters:
WIDTH, 8, shift register width and number of shifts per transfer
DIV_W, 8, width of the shift-rate divider input

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  transfer request
start_ready  output  1  controller idle, request can be accepted
tx_data  input  WIDTH  byte to load, sampled at handshake
msb_first  input  1  0: shift right (LSB out first), 1: shift left (MSB out first); sampled at handshake
div  input  DIV_W  shift period minus 1, in clk cycles; sampled at handshake
abort  input  1  cancels an in-progress transfer
reg_pdata  output  WIDTH  parallel data to the register
reg_load  output  1  register load strobe
reg_shr  output  1  register shift-right strobe
reg_shl  output  1  register shift-left strobe
reg_q  input  WIDTH  register parallel output
rx_data  output  WIDTH  captured register contents after the final shift
rx_valid  output  1  one-cycle pulse, rx_data is new
busy  output  1  transfer in progress (state is not IDLE)

Behaviour:
- Reset: state IDLE; reg_pdata, rx_data = 0; reg_load, reg_shr, reg_shl, rx_valid, busy = 0.
- start_ready = (state == IDLE), so it reads 1 as soon as reset is released.
- All outputs other than start_ready are registered.
- States: IDLE, LOAD, SHIFT, CAPTURE.
- IDLE: when start_valid && start_ready at edge E0:
  - latch tx_data into reg_pdata, and latch msb_first and div;
  - go to LOAD.
  - start_valid with start_ready low is ignored; the requester must hold it.
- LOAD: reg_load = 1 for exactly one cycle (the first cycle after E0). Clear the bit counter, set the tick counter to div, go to SHIFT.
- SHIFT:
  - Tick counter decrements each cycle. In the cycle it equals 0, assert the shift strobe for one cycle: reg_shl if msb_first, else reg_shr.
  - On that strobe, reload the tick counter with div and increment the bit counter.
  - When the strobe for shift number WIDTH is issued, go to CAPTURE.
- Shift timing: strobes are spaced div+1 cycles apart. The first strobe is div+1 cycles after the LOAD cycle. With div = 0, strobes fire on consecutive cycles.
- CAPTURE: one cycle; rx_data <= reg_q at its closing edge and rx_valid = 1 in the following cycle.
- State returns to IDLE in the same cycle rx_valid is high, so a new request may be accepted while rx_valid = 1 (back-to-back transfers, no gap cycle).
- Latency, handshake to rx_valid: 1 (LOAD) + WIDTH*(div+1) (SHIFT) + 1 (CAPTURE) + 1 cycles. For WIDTH = 8, div = 0: rx_valid is high in cycle 11 after E0.
- Exclusivity: at most one of reg_load, reg_shr, reg_shl is high in any cycle. None of them is high in IDLE or CAPTURE.
- reg_pdata holds its value from handshake until the next accepted handshake.
- Abort:
  - abort high in LOAD or SHIFT sends the state to IDLE at that edge. All strobes are 0 from the next cycle, no rx_valid is produced, and rx_data is unchanged.
  - abort in IDLE or CAPTURE is ignored; the transfer completes normally.
- Reset mid-transfer: same as abort, and additionally clears rx_data and reg_pdata. rst has priority over abort and over the handshake.
- div = all-ones: the period is 2^DIV_W cycles; the counter must not overflow or skip.

Decomposition:
- Shared package shreg_ctrl_pkg holds:
  - state encodings as localparam constants (IDLE = 0, LOAD = 1, SHIFT = 2, CAPTURE = 3);
  - default WIDTH and DIV_W;
  - counter width clog2(WIDTH+1).
- One natural sub-module, shreg_tick_div. It is a reloadable down-counter with inputs clk, rst, reload, div and output tick, with tick high when the count is 0.

Test Plan:
- tx_data = 0x13, msb_first = 0, div = 0, reg_q from a behavioural register model with serial_out looped to serial_in:
  - expect reg_load in cycle 1;
  - expect reg_shr in cycles 2–9;
  - expect rx_valid in cycle 11 with rx_data = 0x13.
- tx_data = 0xA5, msb_first = 1, div = 0, serial_in tied 1 → expect 8 reg_shl pulses, no reg_shr pulses, rx_data = 0xFF. Repeat with serial_in tied 0 → rx_data = 0x00.
- div = 3 → strobes 4 cycles apart, first strobe in cycle 5, rx_valid in cycle 35, busy high in cycles 1–34.
- abort asserted the cycle after the 3rd strobe → no further strobes, no rx_valid, start_ready = 1 next cycle, rx_data keeps its previous value.
- rst asserted mid-SHIFT, then released → all outputs 0, start_ready = 1; a new 0x5A loopback transfer completes with rx_data = 0x5A.
- Back-to-back: start_valid held high with tx 0x01 then 0x80 → second handshake in the same cycle as the first rx_valid, each rx_data correct, the exclusive-strobe assertion never fails.
